// File: rtl/gpio_ctrl_pkg.sv
// Shared types for the GPIO controller blocks: interrupt moderator FSM states
// and the width of the fire counter.
package gpio_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLDOFF} intr_mod_state_t;
    localparam int IRQ_CNT_W = 16;
endpackage

// File: rtl/gpio_ctrl_popcount.sv
// Combinational population count of an N-bit vector; the result is wide
// enough to hold N itself.
module gpio_ctrl_popcount #(
    parameter  int N = 4,
    localparam int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/gpio_ctrl_intr_moderator.sv
// Interrupt coalescing between the GPIO status CSR and the CPU IRQ: fires on
// an event-count threshold or a timeout, then enforces an IRQ-low hold-off.
module gpio_ctrl_intr_moderator
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int CNT_W     = 8,
    parameter int TMR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] edge_detected,
    input  logic                 intr_pending,
    input  logic                 cfg_enable,
    input  logic [CNT_W-1:0]     cfg_count_thresh,
    input  logic [TMR_W-1:0]     cfg_timeout,
    input  logic [TMR_W-1:0]     cfg_holdoff,
    output logic                 irq,
    output logic [CNT_W-1:0]     coalesced_count,
    output logic [IRQ_CNT_W-1:0] irq_count
);

    localparam int POP_W = $clog2(NUM_BANKS + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    intr_mod_state_t      state_reg, state_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [TMR_W-1:0]     timer_reg, timer_next;
    logic [TMR_W-1:0]     hold_reg, hold_next;
    logic [CNT_W-1:0]     coal_reg, coal_next;
    logic [IRQ_CNT_W-1:0] irq_count_reg, irq_count_next;
    logic                 irq_reg, irq_next;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count_acc;
    logic [CNT_W-1:0] thresh_eff;
    logic [TMR_W-1:0] hold_load;

    gpio_ctrl_popcount #(.N(NUM_BANKS)) u_popcount (
        .bits  (edge_detected),
        .count (pop)
    );

    // Saturating accumulate; in IDLE count_reg is zero so this is just pop.
    assign sum        = SUM_W'(count_reg) + SUM_W'(pop);
    assign count_acc  = (sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(sum);
    assign thresh_eff = (cfg_count_thresh == '0) ? CNT_W'(1) : cfg_count_thresh;
    assign hold_load  = (cfg_holdoff == '0) ? '0 : cfg_holdoff - TMR_W'(1);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        timer_next     = timer_reg;
        hold_next      = hold_reg;
        coal_next      = coal_reg;
        irq_count_next = irq_count_reg;
        if (!cfg_enable) begin
            state_next = IDLE;
            count_next = '0;
            timer_next = '0;
            hold_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop != '0) begin
                        state_next = ACCUM;
                        count_next = count_acc;
                        timer_next = cfg_timeout;
                    end
                end
                ACCUM: begin
                    if ((count_acc >= thresh_eff) || (timer_reg == '0)) begin
                        state_next     = FIRE;
                        coal_next      = count_acc;
                        count_next     = '0;
                        irq_count_next = irq_count_reg + IRQ_CNT_W'(1);
                    end else begin
                        count_next = count_acc;
                        timer_next = timer_reg - TMR_W'(1);
                    end
                end
                FIRE: begin
                    count_next = count_acc;
                    if (!intr_pending) begin
                        state_next = HOLDOFF;
                        hold_next  = hold_load;
                    end
                end
                HOLDOFF: begin
                    count_next = count_acc;
                    if (hold_reg == '0) begin
                        if ((count_acc != '0) || intr_pending) begin
                            state_next = ACCUM;
                            timer_next = cfg_timeout;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        hold_next = hold_reg - TMR_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        irq_next = (state_next == FIRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            timer_reg     <= '0;
            hold_reg      <= '0;
            coal_reg      <= '0;
            irq_count_reg <= '0;
            irq_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            timer_reg     <= timer_next;
            hold_reg      <= hold_next;
            coal_reg      <= coal_next;
            irq_count_reg <= irq_count_next;
            irq_reg       <= irq_next;
        end
    end

    assign irq             = cfg_enable ? irq_reg : intr_pending;
    assign coalesced_count = coal_reg;
    assign irq_count       = irq_count_reg;

endmodule

// File: tb/tb_gpio_ctrl_intr_moderator.sv
// Scoreboard bench for the interrupt moderator: an event-level reference model
// queues the expected outputs of every cycle, a monitor pops and compares them.
module tb_gpio_ctrl_intr_moderator;
    localparam int NB   = 4;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] edge_detected = '0;
    logic          intr_pending = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [CW-1:0] cfg_count_thresh = 8'd1;
    logic [TW-1:0] cfg_timeout = '0;
    logic [TW-1:0] cfg_holdoff = '0;
    logic          irq;
    logic [CW-1:0] coalesced_count;
    logic [15:0]   irq_count;

    always #5 clk = ~clk;

    gpio_ctrl_intr_moderator #(.NUM_BANKS(NB), .CNT_W(CW), .TMR_W(TW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .edge_detected    (edge_detected),
        .intr_pending     (intr_pending),
        .cfg_enable       (cfg_enable),
        .cfg_count_thresh (cfg_count_thresh),
        .cfg_timeout      (cfg_timeout),
        .cfg_holdoff      (cfg_holdoff),
        .irq              (irq),
        .coalesced_count  (coalesced_count),
        .irq_count        (irq_count)
    );

    typedef struct { int irq; int coal; int fires; } exp_t;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases of the interrupt life cycle, with the event count
    // kept as an unbounded total and deadlines kept as absolute cycle numbers.
    localparam int PH_QUIESCENT = 0, PH_GATHER = 1, PH_ASSERTED = 2, PH_COOLDOWN = 3;
    int ph = PH_QUIESCENT, events = 0, gather_start = 0, cool_start = 0;
    int m_coal = 0, m_fires = 0, cyc = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    initial begin : model
        exp_t e;
        int   pop, thr, ho;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = PH_QUIESCENT; events = 0; m_coal = 0; m_fires = 0;
            end
            e.irq   = cfg_enable ? int'(ph == PH_ASSERTED) : int'(intr_pending);
            e.coal  = m_coal;
            e.fires = m_fires;
            exp_q.push_back(e);
            if (rst_n) begin
                pop = $countones(edge_detected);
                thr = (cfg_count_thresh == 0) ? 1 : int'(cfg_count_thresh);
                ho  = (cfg_holdoff == 0) ? 1 : int'(cfg_holdoff);
                if (!cfg_enable) begin
                    ph = PH_QUIESCENT; events = 0;
                end else if (ph == PH_QUIESCENT) begin
                    if (pop > 0) begin
                        ph = PH_GATHER; events = pop; gather_start = cyc + 1;
                    end
                end else if (ph == PH_GATHER) begin
                    events += pop;
                    if (sat(events) >= thr || (cyc - gather_start) >= int'(cfg_timeout)) begin
                        ph = PH_ASSERTED; m_coal = sat(events); events = 0;
                        m_fires = (m_fires + 1) % 65536;
                    end
                end else if (ph == PH_ASSERTED) begin
                    events += pop;
                    if (!intr_pending) begin
                        ph = PH_COOLDOWN; cool_start = cyc + 1;
                    end
                end else begin
                    events += pop;
                    if ((cyc - cool_start) >= ho - 1) begin
                        if (events > 0 || intr_pending) begin
                            ph = PH_GATHER; gather_start = cyc + 1;
                        end else begin
                            ph = PH_QUIESCENT;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    initial begin : monitor
        exp_t e;
        int   last_fires = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("irq", int'(irq), e.irq);
                check("coalesced_count", int'(coalesced_count), e.coal);
                check("irq_count", int'(irq_count), e.fires);
                if (int'(irq_count) != last_fires) begin
                    $display("fire %0d: coalesced_count=%0d cycle=%0d", irq_count, coalesced_count, cyc);
                    last_fires = int'(irq_count);
                end
            end
        end
    end

    task automatic drive(input logic [NB-1:0] e, input logic p, input logic en);
        @(posedge clk);
        #1;
        edge_detected = e;
        intr_pending  = p;
        cfg_enable    = en;
    endtask

    task automatic configure(input int thr, input int tmo, input int ho);
        drive('0, 1'b0, 1'b0);
        cfg_count_thresh = CW'(thr);
        cfg_timeout      = TW'(tmo);
        cfg_holdoff      = TW'(ho);
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    initial begin : stimulus
        logic [NB-1:0] e;
        logic          p;
        logic          en;
        int            k;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Bypass: irq follows intr_pending combinationally.
        configure(2, 10, 2);
        drive(4'b1010, 1'b0, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        #1 check("bypass_irq_hi", int'(irq), 1);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        #1 check("bypass_irq_lo", int'(irq), 0);

        // Threshold 4: 2 edges at T, 2 more at T+3, irq at T+4.
        configure(4, 1000, 1);
        drive(4'b0011, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0101, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b1);
        sample();
        check("thresh_irq", int'(irq), 1);
        check("thresh_coal", int'(coalesced_count), 4);
        repeat (4) drive('0, 1'b0, 1'b1);

        // Timeout 5: single event at T, irq at T+7.
        configure(10, 5, 1);
        drive(4'b0001, 1'b1, 1'b1);
        repeat (6) drive('0, 1'b1, 1'b1);
        sample();
        check("timeout_irq_early", int'(irq), 0);
        drive('0, 1'b1, 1'b1);
        sample();
        check("timeout_irq", int'(irq), 1);
        check("timeout_coal", int'(coalesced_count), 1);
        repeat (4) drive('0, 1'b0, 1'b1);

        // Hold-off 8 with an edge arriving during the hold-off window.
        configure(1, 100, 8);
        drive(4'b0100, 1'b1, 1'b1);
        repeat (3) drive('0, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b1);
        drive(4'b1000, 1'b1, 1'b1);
        repeat (14) drive('0, 1'b1, 1'b1);
        repeat (12) drive('0, 1'b0, 1'b1);

        // Saturation at 255.
        configure(255, 1000, 1);
        repeat (70) drive(4'b1111, 1'b1, 1'b1);
        sample();
        check("sat_coal", int'(coalesced_count), 255);
        repeat (4) drive('0, 1'b0, 1'b1);

        // Reset while in FIRE drops irq and irq_count immediately.
        configure(1, 0, 1);
        drive(4'b0010, 1'b1, 1'b1);
        k = 0;
        while (irq !== 1'b1 && k < 20) begin
            drive('0, 1'b1, 1'b1);
            k++;
        end
        check("wait_fire", int'(irq), 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_irq", int'(irq), 0);
        check("rst_irq_count", int'(irq_count), 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Disable while accumulating: back to IDLE with the count cleared.
        configure(10, 1000, 1);
        drive(4'b0001, 1'b1, 1'b1);
        drive(4'b0110, 1'b1, 1'b1);
        drive('0, 1'b1, 1'b0);
        drive('0, 1'b1, 1'b0);
        sample();
        check("disable_count", int'(dut.count_reg), 0);
        check("disable_irq_bypass", int'(irq), 1);

        // Randomized traffic with a simple software model driving intr_pending.
        for (int r = 0; r < 20; r++) begin
            configure($urandom_range(0, 6), $urandom_range(0, 20), $urandom_range(0, 10));
            p = 1'b0;
            for (int c = 0; c < 150; c++) begin
                e  = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
                en = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
                if (e != '0) p = 1'b1;
                else if (p && irq && $urandom_range(0, 2) == 0) p = 1'b0;
                else if (p && $urandom_range(0, 40) == 0) p = 1'b0;
                drive(e, p, en);
            end
        end

        repeat (4) drive('0, 1'b0, 1'b0);
        sample();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl_intr_moderator.md
Name: gpio_ctrl_intr_moderator

Overview:
Interrupt moderation (coalescing) controller between the GPIO interrupt-status CSR and the CPU IRQ line. It counts per-bank edge events and asserts the CPU interrupt only when a count threshold or a timeout is reached. After software clears the status, it enforces a hold-off window. When disabled, it passes the CSR level interrupt straight through.

Parameters:
NUM_BANKS, 4, number of per-bank edge pulse inputs (1..32)
CNT_W, 8, width of event counter and threshold
TMR_W, 16, width of timeout and hold-off counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
edge_detected  input  NUM_BANKS  per-bank single-cycle edge pulses, same pulses that feed the status CSR
intr_pending  input  1  level interrupt from the status CSR; high while any status bit is set
cfg_enable  input  1  1 = moderation active, 0 = bypass
cfg_count_thresh  input  CNT_W  event count that fires the IRQ; value 0 is treated as 1
cfg_timeout  input  TMR_W  maximum cycles spent in ACCUM before firing
cfg_holdoff  input  TMR_W  minimum IRQ-low cycles after service; value 0 is treated as 1
irq  output  1  interrupt to CPU
coalesced_count  output  CNT_W  event count captured at the last fire
irq_count  output  16  number of fires since reset; wraps at 2^16

Behaviour:
- Reset: asynchronous on rst_n low. State IDLE; irq=0, coalesced_count=0, irq_count=0, all internal counters 0.
- pop = popcount(edge_detected). count_next = count+pop, saturating at 2^CNT_W-1.
- Bypass (cfg_enable=0): irq = intr_pending, combinational. FSM is held in IDLE, count and timer are cleared, coalesced_count and irq_count hold.
- On a rising cfg_enable, the FSM starts from IDLE the same cycle. On a falling cfg_enable, it returns to IDLE the next cycle from any state.
- In moderated mode, irq is registered and is 1 exactly while the state is FIRE.
- IDLE: irq=0. If pop>0: go to ACCUM, count<=pop, timer<=cfg_timeout.
- ACCUM: count<=count_next.
  - If count_next>=max(thresh,1), or timer==0: go to FIRE. coalesced_count<=count_next, count<=0, irq_count++.
  - Otherwise timer--.
  - Latency: with thresh=1, a pulse at cycle T gives irq=1 at T+2.
  - With timeout=0, a single event also gives irq=1 at T+2.
- FIRE: irq=1. Edges arriving here accumulate into count (saturating).
  - When intr_pending==0 is sampled: go to HOLDOFF, hold<=max(cfg_holdoff,1)-1, count<=count_next.
  - If intr_pending is already 0 on the first FIRE cycle (software cleared early), irq is a 1-cycle pulse. This is legal.
- HOLDOFF: irq=0. Edges accumulate into count.
  - If hold==0: exit. If count_next>0 or intr_pending: go to ACCUM with timer<=cfg_timeout, count<=count_next. Otherwise go to IDLE.
  - Otherwise hold--.
  - Total irq-low time is exactly max(cfg_holdoff,1) cycles.
- Simultaneous events: edges in the same cycle as any transition are never lost. They are folded into count_next, or into pop on the IDLE->ACCUM transition.
- Configuration is sampled live, with no shadowing. Software must change thresholds only while cfg_enable=0. Behaviour after a mid-operation change is defined by the current compare only.
- Reset mid-FIRE drops irq asynchronously, with no glitch beyond the reset edge.

Decomposition:
- gpio_ctrl_pkg:
  - typedef enum logic [1:0] intr_mod_state_t {IDLE, ACCUM, FIRE, HOLDOFF}
  - localparam IRQ_CNT_W=16
- Sub-module gpio_ctrl_popcount: parameterised width N, combinational, $clog2(N+1)-bit output. Reusable by other GPIO blocks.
- Top module holds the FSM, the count/timer/hold counters, and the bypass mux.

Test Plan:
1. Bypass: cfg_enable=0, drive intr_pending 0->1->0 -> irq follows in the same cycle; irq_count stays 0.
2. Threshold: thresh=4, timeout=1000. Pulse edge_detected=4'b0011 at T and 4'b0101 at T+3 -> FIRE at T+4, irq=1 at T+4, coalesced_count=4, irq_count=1.
3. Timeout: thresh=10, timeout=5. Single pulse 4'b0001 at T -> irq=1 at T+7, coalesced_count=1.
4. Hold-off: holdoff=8, fire, then drop intr_pending at cycle F. Pulse during HOLDOFF -> irq=0 for exactly 8 cycles, then ACCUM. With thresh=1, irq re-asserts 1 cycle after HOLDOFF exit.
5. Saturation: thresh=255, drive 4'b1111 for 70 cycles -> count saturates at 255, fires, coalesced_count=255, no wrap.
6. Reset/disable: assert rst_n=0 while in FIRE -> irq=0 immediately, irq_count=0. Separately, cfg_enable falling in ACCUM -> IDLE the next cycle and count=0.
